// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux, fixed-select or round-robin
//
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN
//   When defined, once a beat with in_last=0 is accepted, its channel keeps the
//   grant until that channel's in_last=1 beat is accepted.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   mode          0 = fixed select via sel, 1 = round-robin
//   sel           channel index used when mode=0
//   in_valid      per-channel beat valid
//   in_ready      per-channel accept (combinational, at most one bit set)
//   in_data       channel i at [i*WIDTH +: WIDTH]
//   in_last       per-channel end-of-packet flag
//   out_valid     registered output beat valid
//   out_ready     consumer accept
//   out_data      registered beat data
//   out_last      registered in_last of the beat
//   out_chan      registered source channel of the beat

module stream_mux_rr #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_chan
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SELW-1:0]  lock_ch_q,   lock_ch_d;
`endif

  logic             grant;
  logic [SELW-1:0]  g;
  logic [SELW-1:0]  cand;
  logic             load_ok;
  logic             accept;

  // Grant selection. The round-robin scan runs from the farthest candidate to
  // the nearest, so the last hit (closest to rr_ptr+1) wins.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    cand  = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant = in_valid[lock_ch_q];
      g     = lock_ch_q;
    end else
`endif
    if (!mode) begin
      if ((int'(sel) < NCH) && in_valid[sel]) begin
        grant = 1'b1;
        g     = sel;
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        cand = SELW'((int'(rr_ptr_q) + k) % NCH);
        if (in_valid[cand]) begin
          grant = 1'b1;
          g     = cand;
        end
      end
    end
  end

  assign load_ok = ~out_valid_q | out_ready;
  // Gating with rst keeps in_ready low for the whole reset pulse, including
  // the asynchronous assertion mid-cycle.
  assign accept  = grant & load_ok & ~rst;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[g] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (accept) begin
      // Also covers drain-and-reload in the same cycle: no bubble.
      out_valid_d = 1'b1;
      out_data_d  = in_data[g*WIDTH +: WIDTH];
      out_last_d  = in_last[g];
      out_chan_d  = g;
      if (mode) begin
        rr_ptr_d = g;
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d    = ~in_last[g];
      lock_ch_d = g;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SELW'(NCH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule
